// File: rtl/npc_ras_predictor.sv
// npc_ras_predictor: IF-stage next-fetch-PC selection (sequential / BTB / RAS) with a
// speculative return address stack that is repaired from a pipelined {cnt,sp} checkpoint.
// Optional build macro RAS_TOP_REPAIR_EN: the checkpoint also carries stack[sp] so that
// a top entry clobbered by a wrong-path push can be restored on repair.
module npc_ras_predictor #(
   parameter int unsigned ADDR_WIDTH = 30,
   parameter int unsigned FETCH_LOG  = 1,
   parameter int unsigned RAS_DEPTH  = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(30'h1C00_0000),
   localparam int unsigned PTR_W = $clog2(RAS_DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1,
`ifdef RAS_TOP_REPAIR_EN
   localparam int unsigned CKPT_W = ADDR_WIDTH + CNT_W + PTR_W
`else
   localparam int unsigned CKPT_W = CNT_W + PTR_W
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic [ADDR_WIDTH-1:0] pc_reg,
   input  logic                  taken_pdc,
   input  logic [2:0]            kind_pdc,
   input  logic [ADDR_WIDTH-1:0] npc_btb,
   input  logic                  choice_btb_ras,
   input  logic [ADDR_WIDTH-1:0] call_ret_pdc,
   output logic [ADDR_WIDTH-1:0] npc_pdc,
   output logic [ADDR_WIDTH-1:0] npc_reg,
   output logic [CKPT_W-1:0]     ras_ckpt_pdc,
   output logic                  ras_empty,
   input  logic                  update_en,
   input  logic                  mis_pdc,
   input  logic [2:0]            kind_ex,
   input  logic [ADDR_WIDTH-1:0] ret_pc_ex,
   input  logic [CKPT_W-1:0]     ras_ckpt_ex
);

   localparam logic [2:0] KIND_DIRECT   = 3'd1;
   localparam logic [2:0] KIND_RET      = 3'd4;
   localparam logic [2:0] KIND_INDIRECT = 3'd5;
   localparam logic [2:0] KIND_CALL     = 3'd6;
   localparam logic [2:0] KIND_JUMP     = 3'd7;

   localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ADDR_WIDTH'((2 ** FETCH_LOG) - 1);
   localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(RAS_DEPTH);

   logic [PTR_W-1:0]      sp_q, sp_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] npc_reg_q, npc_reg_d;
   logic [ADDR_WIDTH-1:0] stack_q [RAS_DEPTH];

   logic [ADDR_WIDTH-1:0] stack_top;
   logic [ADDR_WIDTH-1:0] seq_pc;

   logic                  repair;
   logic [PTR_W-1:0]      ex_sp;
   logic [CNT_W-1:0]      ex_cnt;
   logic [PTR_W-1:0]      base_sp;
   logic [CNT_W-1:0]      base_cnt;
   logic [2:0]            op_kind;
   logic [ADDR_WIDTH-1:0] op_data;
   logic                  op_en;
   logic                  push_en;
   logic [PTR_W-1:0]      push_idx;
   logic [ADDR_WIDTH-1:0] push_data;

   assign stack_top = stack_q[sp_q];
   assign repair    = update_en && mis_pdc;
   assign ex_sp     = ras_ckpt_ex[PTR_W-1:0];
   assign ex_cnt    = ras_ckpt_ex[PTR_W+CNT_W-1:PTR_W];

`ifdef RAS_TOP_REPAIR_EN
   logic [ADDR_WIDTH-1:0] ex_top;
   assign ex_top       = ras_ckpt_ex[CKPT_W-1 -: ADDR_WIDTH];
   assign ras_ckpt_pdc = {stack_top, cnt_q, sp_q};
`else
   assign ras_ckpt_pdc = {cnt_q, sp_q};
`endif

   assign ras_empty = (cnt_q == '0);
   assign npc_reg   = npc_reg_q;

   // Next fetch PC: hold on stall, else sequential, BTB or RAS top by branch kind.
   always_comb begin
      seq_pc  = (pc_reg | BLK_MASK) + ADDR_WIDTH'(1);
      npc_pdc = seq_pc;
      if (stall) begin
         npc_pdc = pc_reg;
      end else if (taken_pdc) begin
         case (kind_pdc)
            KIND_RET:
               npc_pdc = (choice_btb_ras && (cnt_q != '0)) ? stack_top : npc_btb;
            KIND_DIRECT, KIND_INDIRECT, KIND_CALL, KIND_JUMP:
               npc_pdc = npc_btb;
            default:
               npc_pdc = seq_pc;
         endcase
      end
      npc_reg_d = npc_pdc;
   end

   // RAS next state: repair (checkpoint + EX op) wins over the speculative predict op.
   always_comb begin
      if (repair) begin
         base_sp  = ex_sp;
         base_cnt = ex_cnt;
         op_kind  = kind_ex;
         op_data  = ret_pc_ex;
         op_en    = 1'b1;
      end else begin
         base_sp  = sp_q;
         base_cnt = cnt_q;
         op_kind  = kind_pdc;
         op_data  = call_ret_pdc;
         op_en    = !stall && taken_pdc;
      end

      sp_d      = base_sp;
      cnt_d     = base_cnt;
      push_en   = 1'b0;
      push_idx  = base_sp + PTR_W'(1);
      push_data = op_data;

      if (op_en && (op_kind == KIND_CALL)) begin
         push_en = 1'b1;
         sp_d    = base_sp + PTR_W'(1);
         cnt_d   = (base_cnt >= CNT_FULL) ? CNT_FULL : base_cnt + CNT_W'(1);
      end else if (op_en && (op_kind == KIND_RET) && (base_cnt != '0)) begin
         sp_d  = base_sp - PTR_W'(1);
         cnt_d = base_cnt - CNT_W'(1);
      end
   end

   // Pointer, count and registered next-PC state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q      <= '0;
         cnt_q     <= '0;
         npc_reg_q <= RESET_PC;
      end else begin
         sp_q      <= sp_d;
         cnt_q     <= cnt_d;
         npc_reg_q <= npc_reg_d;
      end
   end

   // Stack storage (not reset); top restore and push target distinct entries.
   always_ff @(posedge clk) begin
`ifdef RAS_TOP_REPAIR_EN
      if (!rst && repair) begin
         stack_q[ex_sp] <= ex_top;
      end
`endif
      if (!rst && push_en) begin
         stack_q[push_idx] <= push_data;
      end
   end

endmodule

// File: tb/tb_npc_ras_predictor.sv
// tb_npc_ras_predictor: vector table, directed RAS corner sequences and randomized
// traffic checked against a circular-buffer reference model of the predictor.
module tb_npc_ras_predictor;

   localparam int unsigned AW = 30;
   localparam int unsigned FL = 1;
   localparam int          RD = 16;
   localparam int unsigned PW = 4;
   localparam int unsigned CW = PW + 1;
`ifdef RAS_TOP_REPAIR_EN
   localparam int unsigned KW = AW + CW + PW;
`else
   localparam int unsigned KW = CW + PW;
`endif
   localparam logic [AW-1:0] RST_PC = 30'h1C00_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall;
   logic [AW-1:0] pc_reg;
   logic          taken_pdc;
   logic [2:0]    kind_pdc;
   logic [AW-1:0] npc_btb;
   logic          choice_btb_ras;
   logic [AW-1:0] call_ret_pdc;
   logic [AW-1:0] npc_pdc;
   logic [AW-1:0] npc_reg;
   logic [KW-1:0] ras_ckpt_pdc;
   logic          ras_empty;
   logic          update_en;
   logic          mis_pdc;
   logic [2:0]    kind_ex;
   logic [AW-1:0] ret_pc_ex;
   logic [KW-1:0] ras_ckpt_ex;

   always #5 clk = ~clk;

   npc_ras_predictor #(
      .ADDR_WIDTH(AW), .FETCH_LOG(FL), .RAS_DEPTH(RD), .RESET_PC(RST_PC)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .pc_reg(pc_reg), .taken_pdc(taken_pdc),
      .kind_pdc(kind_pdc), .npc_btb(npc_btb), .choice_btb_ras(choice_btb_ras),
      .call_ret_pdc(call_ret_pdc), .npc_pdc(npc_pdc), .npc_reg(npc_reg),
      .ras_ckpt_pdc(ras_ckpt_pdc), .ras_empty(ras_empty), .update_en(update_en),
      .mis_pdc(mis_pdc), .kind_ex(kind_ex), .ret_pc_ex(ret_pc_ex), .ras_ckpt_ex(ras_ckpt_ex)
   );

   int checks   = 0;
   int failures = 0;

   // reference model: circular return stack with modular integer pointers
   logic [AW-1:0] m_stk [RD];
   int            m_sp;
   int            m_cnt;
   logic [AW-1:0] m_npc_reg;
   logic [KW-1:0] hist[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] m_npc();
      longint unsigned blk;
      logic [AW-1:0]   seq;
      blk = longint'(1) << FL;
      seq = AW'(((longint'(pc_reg) / blk) + 1) * blk % (longint'(1) << AW));
      if (stall) return pc_reg;
      if (!taken_pdc) return seq;
      case (kind_pdc)
         3'd4: return (choice_btb_ras && m_cnt != 0) ? m_stk[m_sp] : npc_btb;
         3'd1, 3'd5, 3'd6, 3'd7: return npc_btb;
         default: return seq;
      endcase
   endfunction

   function automatic logic [KW-1:0] m_ckpt();
`ifdef RAS_TOP_REPAIR_EN
      return {m_stk[m_sp], CW'(m_cnt), PW'(m_sp)};
`else
      return {CW'(m_cnt), PW'(m_sp)};
`endif
   endfunction

   // the top field is meaningless while the stack is empty
   function automatic logic [KW-1:0] ckpt_mask(input logic [KW-1:0] v);
      logic [KW-1:0] r;
      r = v;
`ifdef RAS_TOP_REPAIR_EN
      if (v[PW+CW-1:PW] == '0) r[KW-1 -: AW] = '0;
`endif
      return r;
   endfunction

   function automatic void m_apply(input logic [2:0] k, input logic [AW-1:0] data);
      if (k == 3'd6) begin
         m_sp = (m_sp + 1) % RD;
         m_stk[m_sp] = data;
         if (m_cnt < RD) m_cnt++;
      end else if (k == 3'd4 && m_cnt != 0) begin
         m_sp = (m_sp + RD - 1) % RD;
         m_cnt--;
      end
   endfunction

   function automatic void m_clock(input logic [AW-1:0] npc_now);
      m_npc_reg = npc_now;
      if (update_en && mis_pdc) begin
         m_sp  = int'(ras_ckpt_ex[PW-1:0]);
         m_cnt = int'(ras_ckpt_ex[PW+CW-1:PW]);
`ifdef RAS_TOP_REPAIR_EN
         m_stk[m_sp] = ras_ckpt_ex[KW-1 -: AW];
`endif
         m_apply(kind_ex, ret_pc_ex);
      end else if (!stall && taken_pdc) begin
         m_apply(kind_pdc, call_ret_pdc);
      end
   endfunction

   task automatic drive_fe(input logic s, input logic [AW-1:0] pc, input logic t,
                           input logic [2:0] k, input logic [AW-1:0] b, input logic c,
                           input logic [AW-1:0] cr);
      stall = s; pc_reg = pc; taken_pdc = t; kind_pdc = k;
      npc_btb = b; choice_btb_ras = c; call_ret_pdc = cr;
   endtask

   task automatic idle_ex();
      update_en = 1'b0; mis_pdc = 1'b0; kind_ex = 3'd0; ret_pc_ex = '0; ras_ckpt_ex = '0;
   endtask

   task automatic reset_dut();
      drive_fe(1'b0, '0, 1'b0, 3'd0, '0, 1'b0, '0);
      idle_ex();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_sp = 0; m_cnt = 0; m_npc_reg = RST_PC;
      hist.delete();
   endtask

   // one clock: compare all outputs to the model mid-cycle, then advance the model
   task automatic tick(input string tag);
      logic [AW-1:0] e;
      @(negedge clk);
      e = m_npc();
      chk({tag, " npc_pdc"}, 64'(npc_pdc), 64'(e));
      chk({tag, " npc_reg"}, 64'(npc_reg), 64'(m_npc_reg));
      chk({tag, " ckpt"}, 64'(ckpt_mask(ras_ckpt_pdc)), 64'(ckpt_mask(m_ckpt())));
      chk({tag, " empty"}, 64'(ras_empty), 64'(m_cnt == 0));
      @(posedge clk);
      m_clock(e);
      #1;
   endtask

   typedef struct {
      logic          s;
      logic [AW-1:0] pc;
      logic          t;
      logic [2:0]    k;
      logic [AW-1:0] btb;
      logic          c;
      logic [AW-1:0] cr;
      logic [AW-1:0] exp;
   } vec_t;

   vec_t vt [11];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [KW-1:0] k;
      logic [2:0]    kr;
      for (int i = 0; i < RD; i++) m_stk[i] = '0;

      vt[0]  = '{1'b0, 30'h10,       1'b0, 3'd0, 30'h200, 1'b0, 30'h0,  30'h12};
      vt[1]  = '{1'b0, 30'h11,       1'b0, 3'd0, 30'h200, 1'b0, 30'h0,  30'h12};
      vt[2]  = '{1'b0, 30'h10,       1'b1, 3'd1, 30'h200, 1'b0, 30'h0,  30'h200};
      vt[3]  = '{1'b0, 30'h10,       1'b1, 3'd2, 30'h200, 1'b0, 30'h0,  30'h12};
      vt[4]  = '{1'b0, 30'h13,       1'b1, 3'd3, 30'h200, 1'b0, 30'h0,  30'h14};
      vt[5]  = '{1'b0, 30'h10,       1'b1, 3'd5, 30'h300, 1'b0, 30'h0,  30'h300};
      vt[6]  = '{1'b0, 30'h10,       1'b1, 3'd7, 30'h400, 1'b0, 30'h0,  30'h400};
      vt[7]  = '{1'b0, 30'h10,       1'b1, 3'd4, 30'h500, 1'b1, 30'h0,  30'h500};
      vt[8]  = '{1'b1, 30'h77,       1'b1, 3'd6, 30'h600, 1'b1, 30'h77, 30'h77};
      vt[9]  = '{1'b0, 30'h3FFFFFFF, 1'b0, 3'd0, 30'h200, 1'b0, 30'h0,  30'h0};
      vt[10] = '{1'b0, 30'h21,       1'b1, 3'd0, 30'h200, 1'b0, 30'h0,  30'h22};

      // T1: reset state and selection table (stack stays empty throughout)
      reset_dut();
      chk("t1 rst npc_reg", 64'(npc_reg), 64'(RST_PC));
      chk("t1 rst empty", 64'(ras_empty), 64'd1);
      chk("t1 rst ptrs", 64'(ras_ckpt_pdc[PW+CW-1:0]), 64'd0);
      for (int i = 0; i < 11; i++) begin
         drive_fe(vt[i].s, vt[i].pc, vt[i].t, vt[i].k, vt[i].btb, vt[i].c, vt[i].cr);
         #1;
         chk($sformatf("vec%0d npc", i), 64'(npc_pdc), 64'(vt[i].exp));
         tick($sformatf("vec%0d", i));
      end
      chk("t1 still empty", 64'(ras_empty), 64'd1);

      // T2: push then pop via RAS, then pop on empty falls back to BTB
      reset_dut();
      drive_fe(1'b0, 30'h40, 1'b1, 3'd6, 30'h80, 1'b1, 30'h100);
      tick("t2 call");
      drive_fe(1'b0, 30'h80, 1'b1, 3'd4, 30'h999, 1'b1, 30'h0);
      #1;
      chk("t2 ret ras", 64'(npc_pdc), 64'h100);
      chk("t2 cnt1", 64'(ras_ckpt_pdc[PW+CW-1:PW]), 64'd1);
      tick("t2 ret");
      chk("t2 empty", 64'(ras_empty), 64'd1);
      #1;
      chk("t2 ret btb", 64'(npc_pdc), 64'h999);
      tick("t2 ret2");

      // T3: overfill wraps and overwrites the oldest entry
      reset_dut();
      for (int i = 1; i <= 17; i++) begin
         drive_fe(1'b0, 30'h1000, 1'b1, 3'd6, 30'h2000, 1'b1, AW'(i));
         tick("t3 call");
      end
      chk("t3 cnt full", 64'(ras_ckpt_pdc[PW+CW-1:PW]), 64'd16);
      chk("t3 sp wrap", 64'(ras_ckpt_pdc[PW-1:0]), 64'd1);
      for (int i = 0; i < 16; i++) begin
         drive_fe(1'b0, 30'h1000, 1'b1, 3'd4, 30'h3000, 1'b1, 30'h0);
         #1;
         chk($sformatf("t3 ret%0d", i), 64'(npc_pdc), 64'(17 - i));
         tick("t3 ret");
      end
      #1;
      chk("t3 ret empty btb", 64'(npc_pdc), 64'h3000);
      tick("t3 ret17");

      // T4: repair with EX RET after two wrong-path pushes
      reset_dut();
      drive_fe(1'b0, 30'h50, 1'b1, 3'd6, 30'h90, 1'b1, 30'hA); tick("t4 c1");
      drive_fe(1'b0, 30'h50, 1'b1, 3'd6, 30'h90, 1'b1, 30'hB); tick("t4 c2");
      drive_fe(1'b0, 30'h50, 1'b1, 3'd6, 30'h90, 1'b1, 30'hC); tick("t4 c3");
      chk("t4 ckpt", 64'(ras_ckpt_pdc[PW+CW-1:0]), 64'({5'd3, 4'd3}));
`ifdef RAS_TOP_REPAIR_EN
      k = {30'hC, 5'd3, 4'd3};
`else
      k = {5'd3, 4'd3};
`endif
      drive_fe(1'b0, 30'h50, 1'b1, 3'd6, 30'h90, 1'b1, 30'hD); tick("t4 w1");
      drive_fe(1'b0, 30'h50, 1'b1, 3'd6, 30'h90, 1'b1, 30'hE); tick("t4 w2");
      drive_fe(1'b0, 30'h50, 1'b0, 3'd0, 30'h90, 1'b1, 30'h0);
      update_en = 1'b1; mis_pdc = 1'b1; kind_ex = 3'd4; ras_ckpt_ex = k;
      tick("t4 repair");
      idle_ex();
      chk("t4 repaired", 64'(ras_ckpt_pdc[PW+CW-1:0]), 64'({5'd2, 4'd2}));
      drive_fe(1'b0, 30'h50, 1'b1, 3'd4, 30'h90, 1'b1, 30'h0);
      #1;
      chk("t4 ret after repair", 64'(npc_pdc), 64'hB);
      tick("t4 ret");

      // T5: repair + predicted CALL + stall in one cycle
      reset_dut();
      drive_fe(1'b0, 30'h60, 1'b1, 3'd6, 30'h70, 1'b1, 30'h1); tick("t5 c1");
      drive_fe(1'b0, 30'h60, 1'b1, 3'd6, 30'h70, 1'b1, 30'h2); tick("t5 c2");
      drive_fe(1'b0, 30'h60, 1'b1, 3'd6, 30'h70, 1'b1, 30'h3); tick("t5 c3");
`ifdef RAS_TOP_REPAIR_EN
      k = {30'h1, 5'd1, 4'd1};
`else
      k = {5'd1, 4'd1};
`endif
      drive_fe(1'b1, 30'h60, 1'b1, 3'd6, 30'h70, 1'b1, 30'h66);
      update_en = 1'b1; mis_pdc = 1'b1; kind_ex = 3'd6; ret_pc_ex = 30'h55; ras_ckpt_ex = k;
      #1;
      chk("t5 stall npc", 64'(npc_pdc), 64'h60);
      tick("t5 repair");
      idle_ex();
      chk("t5 repaired", 64'(ras_ckpt_pdc[PW+CW-1:0]), 64'({5'd2, 4'd2}));
      drive_fe(1'b0, 30'h60, 1'b1, 3'd4, 30'h70, 1'b1, 30'h0);
      #1;
      chk("t5 ret ex push", 64'(npc_pdc), 64'h55);
      tick("t5 ret1");
      #1;
      chk("t5 ret older", 64'(npc_pdc), 64'h1);
      tick("t5 ret2");

`ifdef RAS_TOP_REPAIR_EN
      // T6: wrong-path RET then CALL clobbers the top; repair restores it
      reset_dut();
      drive_fe(1'b0, 30'h80, 1'b1, 3'd6, 30'h90, 1'b1, 30'h10); tick("t6 c1");
      drive_fe(1'b0, 30'h80, 1'b1, 3'd6, 30'h90, 1'b1, 30'h20); tick("t6 c2");
      k = {30'h20, 5'd2, 4'd2};
      drive_fe(1'b0, 30'h80, 1'b1, 3'd4, 30'h90, 1'b1, 30'h0);  tick("t6 wret");
      drive_fe(1'b0, 30'h80, 1'b1, 3'd6, 30'h90, 1'b1, 30'h99); tick("t6 wcall");
      drive_fe(1'b0, 30'h80, 1'b0, 3'd0, 30'h90, 1'b1, 30'h0);
      update_en = 1'b1; mis_pdc = 1'b1; kind_ex = 3'd0; ras_ckpt_ex = k;
      tick("t6 repair");
      idle_ex();
      drive_fe(1'b0, 30'h80, 1'b1, 3'd4, 30'h90, 1'b1, 30'h0);
      #1;
      chk("t6 top restored", 64'(npc_pdc), 64'h20);
      tick("t6 ret");
`endif

      // randomized traffic with repairs to recently recorded checkpoints
      reset_dut();
      for (int n = 0; n < 3000; n++) begin
         case ($urandom % 8)
            0, 1, 2: kr = 3'd6;
            3, 4, 5: kr = 3'd4;
            default: kr = 3'($urandom);
         endcase
         drive_fe(1'($urandom % 8 == 0), AW'($urandom), 1'($urandom % 4 != 0), kr,
                  AW'($urandom), 1'($urandom % 4 != 0), AW'($urandom));
         if (hist.size() > 0 && $urandom % 8 == 0) begin
            update_en   = 1'b1;
            mis_pdc     = 1'b1;
            kind_ex     = ($urandom % 2 == 0) ? 3'd6 : 3'($urandom);
            ret_pc_ex   = AW'($urandom);
            ras_ckpt_ex = hist[$urandom_range(0, hist.size() - 1)];
         end else begin
            update_en   = 1'($urandom % 4 == 0);
            mis_pdc     = 1'b0;
            kind_ex     = 3'($urandom);
            ret_pc_ex   = AW'($urandom);
            ras_ckpt_ex = m_ckpt();
         end
         hist.push_back(m_ckpt());
         if (hist.size() > 8) void'(hist.pop_front());
         tick("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
